latch_bank_write_arbiter: RTL and testbench

Round-robin write controller sharing one bank of `latch_d` storage words between several requesters. Grants one requester at a time and captures its address and data. Sequences the shared latch data bus and the per-word `enable` lines through a setup / enable / hold cycle so a transparent latch never sees data change while enabled. Sits between the emulator's register-write sources and the latch-based register bank.

---
 rtl/latch_bank_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_latch_bank_write_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_write_arbiter.sv
// ---------------------------------------------------------------------------
// latch_bank_write_arbiter
//
// Round-robin write controller for a bank of transparent latch words.
// One requester at a time is granted; its address and data are captured and
// the shared data bus / per-word enables are sequenced SETUP -> WRITE -> HOLD
// so that a latch never sees its data input change while it is enabled.
//
// Ports
//   clk_i           : clock, all state changes on the rising edge
//   reset_i         : synchronous active-high reset
//   req_i           : per-requester write request (level)
//   req_addr_i      : requester i address at [i*ADDR_BITS +: ADDR_BITS]
//   req_data_i      : requester i data at [i*WIDTH +: WIDTH]
//   grant_o         : one-hot owner of the current transaction, zero when idle
//   ack_o           : one-cycle completion pulse to the owner (HOLD cycle)
//   latch_data_o    : shared data bus to every bank word
//   latch_enable_o  : one-hot word enables, high only during WRITE
//   busy_o          : high in SETUP, WRITE and HOLD
// ---------------------------------------------------------------------------
module latch_bank_write_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int ADDR_BITS     = 3,
   parameter int WIDTH         = 8,
   parameter int ENABLE_CYCLES = 2
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*ADDR_BITS-1:0]  req_addr_i,
   input  logic [NUM_REQ*WIDTH-1:0]      req_data_i,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic [NUM_REQ-1:0]            ack_o,
   output logic [WIDTH-1:0]              latch_data_o,
   output logic [(2**ADDR_BITS)-1:0]     latch_enable_o,
   output logic                          busy_o
);

   localparam int NUM_WORDS = 2 ** ADDR_BITS;
   localparam int IDX_W     = $clog2(NUM_REQ);
   localparam int CNT_W     = (ENABLE_CYCLES > 1) ? $clog2(ENABLE_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_WRITE = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t                 state_q;
   logic [NUM_REQ-1:0]     grant_q;
   logic [NUM_REQ-1:0]     ack_q;
   logic [WIDTH-1:0]       latch_data_q;
   logic [NUM_WORDS-1:0]   latch_enable_q;
   logic                   busy_q;
   logic [IDX_W-1:0]       last_q;
   logic [ADDR_BITS-1:0]   addr_q;
   logic [CNT_W-1:0]       cnt_q;

   logic [NUM_REQ-1:0]     arb_mask_s;
   logic                   arb_valid_s;
   logic [IDX_W-1:0]       arb_idx_s;

   // Round-robin pick: first set bit of mask searching from last+1 upward,
   // wrapping modulo NUM_REQ. Result is {found, index}.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                              input logic [IDX_W-1:0]   last);
      logic [IDX_W:0]   res;
      logic [IDX_W-1:0] idx;
      res = '0;
      // Walk from the farthest candidate to the nearest so the nearest wins.
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = IDX_W'((int'(last) + k) % NUM_REQ);
         if (mask[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Arbitration input: at the end of HOLD the current owner is excluded so
   // a requester that still holds req cannot be granted twice in a row.
   always_comb begin
      arb_mask_s               = (state_q == ST_HOLD) ? (req_i & ~grant_q) : req_i;
      {arb_valid_s, arb_idx_s} = rr_pick(arb_mask_s, last_q);
   end

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q        <= ST_IDLE;
         grant_q        <= '0;
         ack_q          <= '0;
         latch_data_q   <= '0;
         latch_enable_q <= '0;
         busy_q         <= 1'b0;
         last_q         <= IDX_W'(NUM_REQ - 1);
         addr_q         <= '0;
         cnt_q          <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_HOLD: begin
               ack_q          <= '0;
               latch_enable_q <= '0;
               if (arb_valid_s) begin
                  // Launch a new transaction; requester inputs are not
                  // looked at again until it finishes.
                  state_q      <= ST_SETUP;
                  grant_q      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx_s;
                  last_q       <= arb_idx_s;
                  addr_q       <= req_addr_i[arb_idx_s*ADDR_BITS +: ADDR_BITS];
                  latch_data_q <= req_data_i[arb_idx_s*WIDTH +: WIDTH];
                  busy_q       <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
               end
            end
            ST_SETUP: begin
               // Data has been stable for a full cycle; open the word latch.
               state_q        <= ST_WRITE;
               latch_enable_q <= {{(NUM_WORDS-1){1'b0}}, 1'b1} << addr_q;
               cnt_q          <= CNT_W'(ENABLE_CYCLES - 1);
            end
            ST_WRITE: begin
               if (cnt_q == '0) begin
                  // Close the latch and ack; data stays put through HOLD.
                  state_q        <= ST_HOLD;
                  latch_enable_q <= '0;
                  ack_q          <= grant_q;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q        <= ST_IDLE;
               grant_q        <= '0;
               ack_q          <= '0;
               latch_enable_q <= '0;
               busy_q         <= 1'b0;
            end
         endcase
      end
   end

   assign grant_o        = grant_q;
   assign ack_o          = ack_q;
   assign latch_data_o   = latch_data_q;
   assign latch_enable_o = latch_enable_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for latch_bank_write_arbiter (NUM_REQ=4, ADDR_BITS=3, WIDTH=8,
// ENABLE_CYCLES=2) driving a behavioural bank of eight transparent latches.
// ---------------------------------------------------------------------------
module tb_latch_bank_write_arbiter;

   logic        clk;
   logic        reset_i;
   logic [3:0]  req_i;
   logic [11:0] req_addr_i;
   logic [31:0] req_data_i;
   logic [3:0]  grant_o;
   logic [3:0]  ack_o;
   logic [7:0]  latch_data_o;
   logic [7:0]  latch_enable_o;
   logic        busy_o;

   latch_bank_write_arbiter #(
      .NUM_REQ(4), .ADDR_BITS(3), .WIDTH(8), .ENABLE_CYCLES(2)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .req_i(req_i),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .grant_o(grant_o), .ack_o(ack_o), .latch_data_o(latch_data_o),
      .latch_enable_o(latch_enable_o), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Eight transparent latch words: follow the bus while enabled.
   logic [7:0] bank [8] = '{default: 8'h00};
   always @(latch_enable_o or latch_data_o) begin
      for (int w = 0; w < 8; w++) begin
         if (latch_enable_o[w]) bank[w] = latch_data_o;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acks_per [4];
   int sb [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
      req_addr_i[i*3 +: 3] = a;
      req_data_i[i*8 +: 8] = d;
      req_i[i]             = 1'b1;
   endtask

   // Run until n_acks acks arrive; each ack is checked against the expected
   // owner popped from the scoreboard. Requesters drop req on ack unless
   // listed in keep; everything is dropped on the final ack.
   task automatic serve(input int n_acks, input logic [3:0] keep, input int budget);
      int got = 0;
      int last_ack = -1;
      int gap = 0;
      int k = 0;
      int exp_idx;
      bit started = 1'b0;
      while (got < n_acks && k < budget) begin
         tick();
         k++;
         if (busy_o) started = 1'b1;
         else if (started) gap++;
         if (ack_o != 4'd0) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_ack", {28'd0, ack_o}, 32'd0);
            end else begin
               exp_idx = sb.pop_front();
               check("ack_owner", {28'd0, ack_o}, 32'd1 << exp_idx);
               check("grant_at_ack", {28'd0, grant_o}, {28'd0, ack_o});
            end
            if (last_ack >= 0) check("ack_spacing", cyc - last_ack, 32'd4);
            last_ack = cyc;
            got++;
            for (int i = 0; i < 4; i++) begin
               if (ack_o[i]) begin
                  acks_per[i]++;
                  if (!keep[i]) req_i[i] = 1'b0;
               end
            end
            if (got == n_acks) req_i = 4'd0;
         end
      end
      if (got < n_acks) check("serve_timeout_acks", got, n_acks);
      check("no_idle_gap", gap, 32'd0);
   endtask

   typedef struct {
      logic [3:0] grant;
      logic [3:0] ack;
      logic [7:0] data;
      logic [7:0] en;
      logic       busy;
   } vec_t;

   vec_t single_tab [6];

   initial begin
      // Single write req[1], addr 5, data 0xA5: cycles 1..6 after edge 0.
      single_tab[0] = '{4'b0010, 4'b0000, 8'hA5, 8'h00, 1'b1};
      single_tab[1] = '{4'b0010, 4'b0000, 8'hA5, 8'h20, 1'b1};
      single_tab[2] = '{4'b0010, 4'b0000, 8'hA5, 8'h20, 1'b1};
      single_tab[3] = '{4'b0010, 4'b0010, 8'hA5, 8'h00, 1'b1};
      single_tab[4] = '{4'b0000, 4'b0000, 8'hA5, 8'h00, 1'b0};
      single_tab[5] = '{4'b0000, 4'b0000, 8'hA5, 8'h00, 1'b0};

      reset_i    = 1'b1;
      req_i      = 4'd0;
      req_addr_i = 12'd0;
      req_data_i = 32'd0;
      for (int i = 0; i < 4; i++) acks_per[i] = 0;
      tick();
      tick();
      check("rst_grant", {28'd0, grant_o}, 32'd0);
      check("rst_ack",   {28'd0, ack_o}, 32'd0);
      check("rst_en",    {24'd0, latch_enable_o}, 32'd0);
      check("rst_data",  {24'd0, latch_data_o}, 32'd0);
      check("rst_busy",  {31'd0, busy_o}, 32'd0);
      reset_i = 1'b0;
      tick();

      // ---- Single write, table-driven ----
      set_req(1, 3'd5, 8'hA5);
      for (int c = 0; c < 6; c++) begin
         tick();
         check("single_grant", {28'd0, grant_o}, {28'd0, single_tab[c].grant});
         check("single_ack",   {28'd0, ack_o},   {28'd0, single_tab[c].ack});
         check("single_data",  {24'd0, latch_data_o}, {24'd0, single_tab[c].data});
         check("single_en",    {24'd0, latch_enable_o}, {24'd0, single_tab[c].en});
         check("single_busy",  {31'd0, busy_o}, {31'd0, single_tab[c].busy});
         if (ack_o[1]) req_i[1] = 1'b0;
      end
      check("single_word5", {24'd0, bank[5]}, 32'hA5);

      // ---- All four from reset: grants 0,1,2,3 back to back ----
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 3'(i), 8'h10 + 8'(i));
      for (int i = 0; i < 4; i++) sb.push_back(i);
      serve(4, 4'b0000, 40);
      for (int i = 0; i < 4; i++) check("all4_word", {24'd0, bank[i]}, 32'h10 + i);

      // ---- Fairness: req[0] and req[2] held continuously ----
      for (int i = 0; i < 4; i++) acks_per[i] = 0;
      set_req(0, 3'd1, 8'h41);
      set_req(2, 3'd2, 8'h42);
      for (int r = 0; r < 3; r++) begin
         sb.push_back(0);
         sb.push_back(2);
      end
      serve(6, 4'b0101, 60);
      check("fair_balance", ((acks_per[0] - acks_per[2]) <= 1 && (acks_per[2] - acks_per[0]) <= 1) ? 32'd1 : 32'd0, 32'd1);
      for (int k = 0; k < 10 && busy_o; k++) tick();
      check("fair_idle", {31'd0, busy_o}, 32'd0);

      // ---- Only req[3], dropped after ack: back to IDLE ----
      set_req(3, 3'd7, 8'h5A);
      sb.push_back(3);
      serve(1, 4'b0000, 20);
      tick();
      tick();
      tick();
      check("solo_busy",  {31'd0, busy_o}, 32'd0);
      check("solo_grant", {28'd0, grant_o}, 32'd0);
      check("solo_word7", {24'd0, bank[7]}, 32'h5A);

      // ---- req_data changes during WRITE ----
      set_req(0, 3'd4, 8'h3C);
      tick();
      check("dchg_data_setup", {24'd0, latch_data_o}, 32'h3C);
      tick();
      check("dchg_en", {24'd0, latch_enable_o}, 32'h10);
      req_data_i[7:0] = 8'hFF;
      tick();
      check("dchg_data_write", {24'd0, latch_data_o}, 32'h3C);
      tick();
      check("dchg_ack", {28'd0, ack_o}, 32'h1);
      check("dchg_data_hold", {24'd0, latch_data_o}, 32'h3C);
      req_i = 4'd0;
      tick();
      check("dchg_word4", {24'd0, bank[4]}, 32'h3C);

      // ---- Reset in first WRITE cycle of a write to word 6 ----
      set_req(2, 3'd6, 8'h77);
      tick();
      tick();
      check("rstw_en", {24'd0, latch_enable_o}, 32'h40);
      reset_i = 1'b1;
      tick();
      check("rstw_grant", {28'd0, grant_o}, 32'd0);
      check("rstw_ack",   {28'd0, ack_o}, 32'd0);
      check("rstw_en0",   {24'd0, latch_enable_o}, 32'd0);
      check("rstw_data",  {24'd0, latch_data_o}, 32'd0);
      check("rstw_busy",  {31'd0, busy_o}, 32'd0);
      reset_i = 1'b0;
      req_i   = 4'd0;
      set_req(0, 3'd0, 8'h20);
      set_req(1, 3'd1, 8'h21);
      sb.push_back(0);
      sb.push_back(1);
      serve(2, 4'b0000, 30);
      check("rstw_word0", {24'd0, bank[0]}, 32'h20);
      check("rstw_word1", {24'd0, bank[1]}, 32'h21);
      check("sb_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
